ee357_pc_update_unit: RTL and testbench

//   Parametrised program-counter update unit for the multicycle CPU; successor to the

---
 rtl/ee357_pc_update_unit.sv | 136 +++++++++++++
 tb/tb_ee357_pc_update_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ee357_pc_update_unit.sv
// Program-counter update unit: owns the PC register, resolves (optionally inverted)
// branch conditions, holds a redirect across stalls and keeps a small return-address stack.
module ee357_pc_update_unit #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      INC       = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'('h80),
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pc_write,
    input  logic             pc_write_cond,
    input  logic [1:0]       cond_sel,
    input  logic             cond_inv,
    input  logic [3:0]       flags,
    input  logic [1:0]       src_sel,
    input  logic [WIDTH-1:0] target,
    input  logic             push,
    input  logic             stall,
    output logic             take,
    output logic [WIDTH-1:0] pc,
    output logic             pc_written,
    output logic             pending,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    localparam int unsigned IW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_TARGET = 2'd1,
        SRC_RAS    = 2'd2,
        SRC_EXC    = 2'd3
    } src_e;

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [CW-1:0]    ras_count;
    logic [IW-1:0]    top_idx;
    logic [IW-1:0]    free_idx;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] next_addr;
    logic [WIDTH-1:0] pend_addr;
    logic             do_pop;
    logic             do_push;

    assign take      = pc_write | (pc_write_cond & (flags[cond_sel] ^ cond_inv));
    assign pc_inc    = pc + WIDTH'(INC);
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CW'(RAS_DEPTH));
    assign top_idx   = IW'(ras_count - CW'(1));
    assign free_idx  = IW'(ras_count);
    assign do_pop    = take & (src_e'(src_sel) == SRC_RAS);
    assign do_push   = take & push;

    // NOTE: every always_comb output gets a default before the case so no latch is inferred.
    always_comb begin
        next_addr = pc_inc;
        case (src_e'(src_sel))
            SRC_SEQ:    next_addr = pc_inc;
            SRC_TARGET: next_addr = target;
            SRC_RAS:    next_addr = ras_empty ? EXC_VEC : ras_mem[top_idx];
            SRC_EXC:    next_addr = EXC_VEC;
            default:    next_addr = pc_inc;
        endcase
    end

    // NOTE: the stack storage is deliberately not reset; ras_count alone defines which
    // entries are valid, so the array maps onto plain registers without a reset net.
    always_ff @(posedge clk) begin
        if (do_push) begin
            if (do_pop && !ras_empty) begin
                ras_mem[top_idx] <= pc_inc;
            end else if (!ras_full) begin
                ras_mem[free_idx] <= pc_inc;
            end
        end
    end

    // An underflowing pop leaves the stack empty, so a simultaneous push lands in slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_count <= '0;
            ras_err   <= 1'b0;
        end else begin
            case ({do_push, do_pop})
                2'b01: begin
                    if (ras_empty) ras_err   <= 1'b1;
                    else           ras_count <= ras_count - CW'(1);
                end
                2'b10: begin
                    if (ras_full) ras_err   <= 1'b1;
                    else          ras_count <= ras_count + CW'(1);
                end
                2'b11: begin
                    if (ras_empty) begin
                        ras_err   <= 1'b1;
                        ras_count <= CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_VEC;
            pend_addr  <= RESET_VEC;
            pending    <= 1'b0;
            pc_written <= 1'b0;
        end else begin
            pc_written <= 1'b0;
            if (take) begin
                if (stall) begin
                    pend_addr <= next_addr;
                    pending   <= 1'b1;
                end else begin
                    pc         <= next_addr;
                    pending    <= 1'b0;
                    pc_written <= 1'b1;
                end
            end else if (!stall && pending) begin
                pc         <= pend_addr;
                pending    <= 1'b0;
                pc_written <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ee357_pc_update_unit.sv
// Self-checking bench for ee357_pc_update_unit: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_ee357_pc_update_unit;

    localparam logic [31:0] EXC   = 32'h80;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b0;
    logic        pc_write_cond = 1'b0;
    logic [1:0]  cond_sel = 2'd0;
    logic        cond_inv = 1'b0;
    logic [3:0]  flags = 4'd0;
    logic [1:0]  src_sel = 2'd0;
    logic [31:0] target = 32'd0;
    logic        push = 1'b0;
    logic        stall = 1'b0;
    logic        take;
    logic [31:0] pc;
    logic        pc_written;
    logic        pending;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_pend_addr;
    bit          m_pending;
    bit          m_written;
    bit          m_err;
    logic [31:0] ras_q[$];

    ee357_pc_update_unit dut (
        .clk(clk), .rst_n(rst_n), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
        .cond_sel(cond_sel), .cond_inv(cond_inv), .flags(flags), .src_sel(src_sel),
        .target(target), .push(push), .stall(stall), .take(take), .pc(pc),
        .pc_written(pc_written), .pending(pending), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_err(ras_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        m_pend_addr = 32'd0;
        m_pending = 0;
        m_written = 0;
        m_err = 0;
        ras_q.delete();
    endtask

    task automatic drive(input logic pw, input logic pwc, input logic [1:0] cs, input logic inv,
                         input logic [3:0] fl, input logic [1:0] src, input logic [31:0] tgt,
                         input logic psh, input logic stl);
        pc_write = pw; pc_write_cond = pwc; cond_sel = cs; cond_inv = inv;
        flags = fl; src_sel = src; target = tgt; push = psh; stall = stl;
    endtask

    task automatic check_state(input string tag);
        check({tag, ":pc"}, pc, m_pc);
        check({tag, ":pending"}, 32'(pending), 32'(m_pending));
        check({tag, ":pc_written"}, 32'(pc_written), 32'(m_written));
        check({tag, ":ras_empty"}, 32'(ras_empty), 32'(ras_q.size() == 0));
        check({tag, ":ras_full"}, 32'(ras_full), 32'(ras_q.size() == DEPTH));
        check({tag, ":ras_err"}, 32'(ras_err), 32'(m_err));
    endtask

    // One clock cycle: inputs are already applied; model predicts, then the edge is taken.
    task automatic step(input string tag);
        logic [31:0] nxt;
        logic [31:0] seq;
        bit          t;
        #1;
        t = pc_write || (pc_write_cond && (flags[cond_sel] != cond_inv));
        check({tag, ":take"}, 32'(take), 32'(t));
        seq = m_pc + 32'd4;
        case (src_sel)
            2'd0:    nxt = seq;
            2'd1:    nxt = target;
            2'd2:    nxt = (ras_q.size() != 0) ? ras_q[$] : EXC;
            default: nxt = EXC;
        endcase
        if (t && src_sel == 2'd2) begin
            if (ras_q.size() == 0) m_err = 1;
            else void'(ras_q.pop_back());
            if (push) ras_q.push_back(seq);
        end else if (t && push) begin
            if (ras_q.size() == DEPTH) m_err = 1;
            else ras_q.push_back(seq);
        end
        m_written = 0;
        if (t) begin
            if (stall) begin
                m_pend_addr = nxt;
                m_pending = 1;
            end else begin
                m_pc = nxt;
                m_pending = 0;
                m_written = 1;
            end
        end else if (!stall && m_pending) begin
            m_pc = m_pend_addr;
            m_pending = 0;
            m_written = 1;
        end
        @(posedge clk);
        #1;
        check_state(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, ":pc"}, pc, 32'd0);
        check({tag, ":pending"}, 32'(pending), 32'd0);
        check({tag, ":ras_empty"}, 32'(ras_empty), 32'd1);
        check({tag, ":ras_err"}, 32'(ras_err), 32'd0);
        check({tag, ":pc_written"}, 32'(pc_written), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state({tag, ":post"});
    endtask

    task automatic set_pc(input logic [31:0] v);
        drive(1, 0, 0, 0, 0, 2'd1, v, 0, 0);
        step("set_pc");
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_state("reset");

        // Conditional branch on Z, non-inverted then inverted
        set_pc(32'h100);
        drive(0, 1, 2'd0, 0, 4'b0001, 2'd1, 32'h200, 0, 0);
        step("cond_z");
        check("cond_z:pc_abs", pc, 32'h200);
        check("cond_z:pulse", 32'(pc_written), 32'd1);
        set_pc(32'h100);
        drive(0, 1, 2'd0, 1, 4'b0001, 2'd1, 32'h200, 0, 0);
        step("cond_z_inv");
        check("cond_z_inv:pc_abs", pc, 32'h100);

        // Other flags, both polarities
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 2'(i), 1'(i % 2), 4'(1 << i), 2'd0, 0, 0, 0);
            step("cond_flag");
        end

        // Stall hold and release
        set_pc(32'h100);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 2'd1, 0, 4'b0010, 2'd1, 32'h300, 0, 1);
            step("stall_hold");
        end
        check("stall_hold:pc_abs", pc, 32'h100);
        check("stall_hold:pend_abs", 32'(pending), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("release");
        check("release:pc_abs", pc, 32'h300);

        // Stalled takes overwrite; a new take with stall low drops the held one
        drive(1, 0, 0, 0, 0, 2'd1, 32'h600, 0, 1);
        step("stall_a");
        drive(1, 0, 0, 0, 0, 2'd1, 32'h700, 0, 1);
        step("stall_b");
        drive(1, 0, 0, 0, 0, 2'd1, 32'h800, 0, 0);
        step("simul");
        check("simul:pc_abs", pc, 32'h800);

        // Reset while a redirect is held
        drive(1, 0, 0, 0, 0, 2'd1, 32'h900, 0, 1);
        step("pre_rst");
        async_reset("rst_mid_stall");

        // Call / return
        set_pc(32'h40);
        drive(1, 0, 0, 0, 0, 2'd1, 32'h500, 1, 0);
        step("call");
        check("call:pc_abs", pc, 32'h500);
        drive(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        step("ret");
        check("ret:pc_abs", pc, 32'h44);
        check("ret:empty_abs", 32'(ras_empty), 32'd1);

        // RAS overflow then drain and underflow
        for (int i = 0; i < DEPTH + 1; i++) begin
            drive(1, 0, 0, 0, 0, 2'd0, 0, 1, 0);
            step("ovf_push");
        end
        check("ovf:full_abs", 32'(ras_full), 32'd1);
        check("ovf:err_abs", 32'(ras_err), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
            step("drain");
        end
        drive(1, 0, 0, 0, 0, 2'd2, 0, 0, 0);
        step("underflow");
        check("underflow:pc_abs", pc, EXC);

        // Wrap
        set_pc(32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0, 2'd0, 0, 0, 0);
        step("wrap");
        check("wrap:pc_abs", pc, 32'd0);

        // Random traffic
        async_reset("rst_rand");
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                  2'($urandom), 1'($urandom), 4'($urandom), 2'($urandom),
                  {$urandom} & 32'hFFFF_FFFC, 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 9) < 3));
            step("rand");
            if (i == 200) async_reset("rst_rand_mid");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
